// File: rtl/scratch_pad_ctrl.sv
// Scratch pad load/compute sequencer: streams activation then weight words into BRAMs, then issues NDP reads.
// Optional load-stall counter enabled with SCRATCH_PAD_CTRL_PERF_EN.
module scratch_pad_ctrl #(
    parameter int unsigned N_ACT  = 1,
    parameter int unsigned N_WGT  = 64,
    parameter int unsigned LAYERS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        rd_ready,
    output logic [2:0]  step,
    output logic [5:0]  bram_num,
    output logic        bram_addr,
    output logic [2:0]  bram_layer,
    output logic [31:0] data_received,
    output logic [2:0]  data_address_into_ndp_unit,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] stall_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_ACT,
        S_LOAD_WGT,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    localparam logic [5:0] ACT_LAST   = 6'(N_ACT - 1);
    localparam logic [5:0] WGT_LAST   = 6'(N_WGT - 1);
    localparam logic [2:0] LAYER_LAST = 3'(LAYERS - 1);
    localparam logic [2:0] RD_LAST    = 3'(2 * LAYERS - 1);

    state_t      r_state;
    state_t      w_next;

    logic        r_addr_cnt;
    logic [5:0]  r_num_cnt;
    logic [2:0]  r_layer_cnt;
    logic [2:0]  r_rd_addr;
    logic        r_rd_valid;

    logic [2:0]  r_step;
    logic [5:0]  r_bram_num;
    logic        r_bram_addr;
    logic [2:0]  r_bram_layer;
    logic [31:0] r_data;

    logic        w_loading;
    logic        w_beat;
    logic        w_num_last;
    logic        w_last_beat;
    logic        w_issue;
    logic        w_rd_last;
    logic        w_start;

    assign w_loading   = (r_state == S_LOAD_ACT) || (r_state == S_LOAD_WGT);
    assign w_beat      = w_loading && in_valid;
    assign w_num_last  = (r_state == S_LOAD_ACT) ? (r_num_cnt == ACT_LAST)
                                                 : (r_num_cnt == WGT_LAST);
    assign w_last_beat = w_beat && r_addr_cnt && w_num_last && (r_layer_cnt == LAYER_LAST);
    // Reads start once step shows 3, leaving the final weight tuple visible for one cycle.
    assign w_issue     = (r_state == S_COMPUTE) && (r_step == 3'd3) && rd_ready;
    assign w_rd_last   = w_issue && (r_rd_addr == RD_LAST);
    assign w_start     = (r_state == S_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_LOAD_ACT;
            end
            S_LOAD_ACT: begin
                in_ready = 1'b1;
                if (w_last_beat) w_next = S_LOAD_WGT;
            end
            S_LOAD_WGT: begin
                in_ready = 1'b1;
                if (w_last_beat) w_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (w_rd_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_cnt  <= 1'b0;
            r_num_cnt   <= '0;
            r_layer_cnt <= '0;
        end else if (w_start) begin
            r_addr_cnt  <= 1'b0;
            r_num_cnt   <= '0;
            r_layer_cnt <= '0;
        end else if (w_beat) begin
            r_addr_cnt <= ~r_addr_cnt;
            if (r_addr_cnt) begin
                if (w_num_last) begin
                    r_num_cnt   <= '0;
                    r_layer_cnt <= (r_layer_cnt == LAYER_LAST) ? 3'd0 : r_layer_cnt + 3'd1;
                end else begin
                    r_num_cnt <= r_num_cnt + 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step       <= '0;
            r_bram_num   <= '0;
            r_bram_addr  <= 1'b0;
            r_bram_layer <= '0;
            r_data       <= '0;
        end else if (w_beat) begin
            r_step       <= (r_state == S_LOAD_ACT) ? 3'd1 : 3'd2;
            r_bram_num   <= r_num_cnt;
            r_bram_addr  <= r_addr_cnt;
            r_bram_layer <= r_layer_cnt;
            r_data       <= in_data;
        end else if (r_state == S_COMPUTE) begin
            r_step <= 3'd3;
        end else if (r_state == S_DRAIN) begin
            r_step <= 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_issue;
            if (w_issue) r_rd_addr <= w_rd_last ? 3'd0 : r_rd_addr + 3'd1;
        end
    end

`ifdef SCRATCH_PAD_CTRL_PERF_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                            r_stall <= '0;
        else if (w_start)                                      r_stall <= '0;
        else if (w_loading && !in_valid && (r_stall != '1))    r_stall <= r_stall + 16'd1;
    end

    assign stall_cnt = r_stall;
`else
    assign stall_cnt = '0;
`endif

    assign step                       = r_step;
    assign bram_num                   = r_bram_num;
    assign bram_addr                  = r_bram_addr;
    assign bram_layer                 = r_bram_layer;
    assign data_received              = r_data;
    assign data_address_into_ndp_unit = r_rd_addr;
    assign rd_valid                   = r_rd_valid;

endmodule

// File: tb/tb_scratch_pad_ctrl.sv
// Directed table-driven bench for scratch_pad_ctrl with N_ACT=1, N_WGT=2, LAYERS=2.
module tb_scratch_pad_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        rd_ready;
    logic [2:0]  step;
    logic [5:0]  bram_num;
    logic        bram_addr;
    logic [2:0]  bram_layer;
    logic [31:0] data_received;
    logic [2:0]  data_address_into_ndp_unit;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic [15:0] stall_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

`ifdef SCRATCH_PAD_CTRL_PERF_EN
    localparam logic [15:0] EXP_STALL = 16'd3;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    scratch_pad_ctrl #(.N_ACT(1), .N_WGT(2), .LAYERS(2)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .start                      (start),
        .in_valid                   (in_valid),
        .in_data                    (in_data),
        .in_ready                   (in_ready),
        .rd_ready                   (rd_ready),
        .step                       (step),
        .bram_num                   (bram_num),
        .bram_addr                  (bram_addr),
        .bram_layer                 (bram_layer),
        .data_received              (data_received),
        .data_address_into_ndp_unit (data_address_into_ndp_unit),
        .rd_valid                   (rd_valid),
        .busy                       (busy),
        .done                       (done),
        .stall_cnt                  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  step;
        logic [5:0]  num;
        logic        addr;
        logic [2:0]  layer;
    } beat_t;

    typedef struct packed {
        logic       rr;
        logic [2:0] step;
        logic [2:0] addr;
        logic       rv;
        logic       done;
        logic       busy;
    } cmp_t;

    beat_t beats [12];
    cmp_t  cmp_a [7];
    cmp_t  cmp_b [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_tuple(input string nm, input beat_t b);
        chk({nm, ".step"},  32'(step),          32'(b.step));
        chk({nm, ".num"},   32'(bram_num),      32'(b.num));
        chk({nm, ".addr"},  32'(bram_addr),     32'(b.addr));
        chk({nm, ".layer"}, 32'(bram_layer),    32'(b.layer));
        chk({nm, ".data"},  data_received,      b.data);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start.busy",     32'(busy),     32'd1);
        chk("start.in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic load(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            chk($sformatf("beat%0d.in_ready", i), 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = beats[i].data;
            tick();
            chk_tuple($sformatf("beat%0d", i), beats[i]);
        end
        in_valid = 1'b0;
    endtask

    task automatic compute_a();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("cmpA%0d.step", i), 32'(step), 32'(cmp_a[i].step));
            chk($sformatf("cmpA%0d.ra", i),   32'(data_address_into_ndp_unit), 32'(cmp_a[i].addr));
            chk($sformatf("cmpA%0d.rv", i),   32'(rd_valid), 32'(cmp_a[i].rv));
            chk($sformatf("cmpA%0d.done", i), 32'(done), 32'(cmp_a[i].done));
            chk($sformatf("cmpA%0d.busy", i), 32'(busy), 32'(cmp_a[i].busy));
            rd_ready = cmp_a[i].rr;
            tick();
        end
    endtask

    task automatic compute_b();
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("cmpB%0d.step", i), 32'(step), 32'(cmp_b[i].step));
            chk($sformatf("cmpB%0d.ra", i),   32'(data_address_into_ndp_unit), 32'(cmp_b[i].addr));
            chk($sformatf("cmpB%0d.rv", i),   32'(rd_valid), 32'(cmp_b[i].rv));
            chk($sformatf("cmpB%0d.done", i), 32'(done), 32'(cmp_b[i].done));
            chk($sformatf("cmpB%0d.busy", i), 32'(busy), 32'(cmp_b[i].busy));
            rd_ready = cmp_b[i].rr;
            tick();
        end
    endtask

    initial begin
        // act: addr innermost, then num (only 0), then layer
        beats[0]  = '{32'hA000_0000, 3'd1, 6'd0, 1'b0, 3'd0};
        beats[1]  = '{32'hA000_0001, 3'd1, 6'd0, 1'b1, 3'd0};
        beats[2]  = '{32'hA000_0002, 3'd1, 6'd0, 1'b0, 3'd1};
        beats[3]  = '{32'hA000_0003, 3'd1, 6'd0, 1'b1, 3'd1};
        beats[4]  = '{32'hB000_0000, 3'd2, 6'd0, 1'b0, 3'd0};
        beats[5]  = '{32'hB000_0001, 3'd2, 6'd0, 1'b1, 3'd0};
        beats[6]  = '{32'hB000_0002, 3'd2, 6'd1, 1'b0, 3'd0};
        beats[7]  = '{32'hB000_0003, 3'd2, 6'd1, 1'b1, 3'd0};
        beats[8]  = '{32'hB000_0004, 3'd2, 6'd0, 1'b0, 3'd1};
        beats[9]  = '{32'hB000_0005, 3'd2, 6'd0, 1'b1, 3'd1};
        beats[10] = '{32'hB000_0006, 3'd2, 6'd1, 1'b0, 3'd1};
        beats[11] = '{32'hB000_0007, 3'd2, 6'd1, 1'b1, 3'd1};

        // rr, step, addr, rv, done, busy; row 0 is the cycle after the last weight beat
        cmp_a[0] = '{1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1};
        cmp_a[1] = '{1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1};
        cmp_a[2] = '{1'b1, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1};
        cmp_a[3] = '{1'b1, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1};
        cmp_a[4] = '{1'b1, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1};
        cmp_a[5] = '{1'b1, 3'd3, 3'd0, 1'b1, 1'b1, 1'b1};
        cmp_a[6] = '{1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};

        cmp_b[0] = '{1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1};
        cmp_b[1] = '{1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1};
        cmp_b[2] = '{1'b1, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1};
        cmp_b[3] = '{1'b0, 3'd3, 3'd2, 1'b1, 1'b0, 1'b1};
        cmp_b[4] = '{1'b0, 3'd3, 3'd2, 1'b0, 1'b0, 1'b1};
        cmp_b[5] = '{1'b1, 3'd3, 3'd2, 1'b0, 1'b0, 1'b1};
        cmp_b[6] = '{1'b1, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1};
        cmp_b[7] = '{1'b1, 3'd3, 3'd0, 1'b1, 1'b1, 1'b1};
        cmp_b[8] = '{1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_ready = 1'b1;
        tick();
        tick();
        chk("rst.step",     32'(step),          32'd0);
        chk("rst.busy",     32'(busy),          32'd0);
        chk("rst.in_ready", 32'(in_ready),      32'd0);
        chk("rst.data",     data_received,      32'd0);
        chk("rst.rv",       32'(rd_valid),      32'd0);
        chk("rst.stall",    32'(stall_cnt),     32'd0);
        rst_n = 1'b1;
        in_valid = 1'b1;
        tick();
        chk("idle.in_ready", 32'(in_ready), 32'd0);
        chk("idle.busy",     32'(busy),     32'd0);
        in_valid = 1'b0;

        // Run A: continuous input, rd_ready always high
        do_start();
        load(0, 11);
        chk("runA.in_ready_compute", 32'(in_ready), 32'd0);
        chk("runA.stall", 32'(stall_cnt), 32'd0);
        compute_a();

        // Run B: 3 idle input cycles between act and weight, rd_ready stall on address 2
        do_start();
        load(0, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_tuple($sformatf("gap%0d", i), beats[3]);
            chk($sformatf("gap%0d.in_ready", i), 32'(in_ready), 32'd1);
        end
        load(4, 11);
        chk("runB.stall", 32'(stall_cnt), 32'(EXP_STALL));
        compute_b();

        // Run C: start during weight load is ignored, then reset during weight beat 5
        do_start();
        load(0, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_tuple("ignstart", beats[5]);
        chk("ignstart.busy", 32'(busy), 32'd1);
        load(6, 8);
        in_valid = 1'b1;
        in_data  = beats[9].data;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.step",     32'(step),     32'd0);
        chk("midrst.busy",     32'(busy),     32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd0);
        chk("midrst.num",      32'(bram_num), 32'd0);
        chk("midrst.data",     data_received, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("postrst.busy", 32'(busy),  32'd0);
        chk("postrst.step", 32'(step),  32'd0);
        in_valid = 1'b0;
        do_start();
        load(0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
